// File: rtl/seg7_digit_mux.sv
// Digit-data stage for a 4-digit multiplexed 7-segment display: double-buffered
// hex value, hex decode, leading-zero blanking, per-digit blink, registered cathodes.
module seg7_digit_mux #(
   parameter int unsigned BLINK_FRAMES   = 64,
   parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic [1:0]  i_Sel,
   input  logic [15:0] i_Data,
   input  logic [3:0]  i_Dp,
   input  logic        i_Load,
   output logic        o_Ready,
   input  logic        i_Blank_Lz,
   input  logic [3:0]  i_Blink,
   output logic [6:0]  o_Seg,
   output logic        o_Dp
);

   localparam int unsigned     CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [6:0]       SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
   localparam logic             DP_OFF   = ACTIVE_LOW_SEG ? 1'b1 : 1'b0;

   logic [15:0]      active_data, shadow_data;
   logic [3:0]       active_dp, shadow_dp;
   logic             pending;
   logic [1:0]       prev_sel;
   logic [CNT_W-1:0] blink_cnt;
   logic             blink_phase;

   logic             boundary;
   logic [3:0]       nib;
   logic             lz_dark, blink_dark;
   logic [6:0]       seg_raw;
   logic             dp_raw;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0: hex_to_seg = 7'h3F;
         4'h1: hex_to_seg = 7'h06;
         4'h2: hex_to_seg = 7'h5B;
         4'h3: hex_to_seg = 7'h4F;
         4'h4: hex_to_seg = 7'h66;
         4'h5: hex_to_seg = 7'h6D;
         4'h6: hex_to_seg = 7'h7D;
         4'h7: hex_to_seg = 7'h07;
         4'h8: hex_to_seg = 7'h7F;
         4'h9: hex_to_seg = 7'h6F;
         4'hA: hex_to_seg = 7'h77;
         4'hB: hex_to_seg = 7'h7C;
         4'hC: hex_to_seg = 7'h39;
         4'hD: hex_to_seg = 7'h5E;
         4'hE: hex_to_seg = 7'h79;
         default: hex_to_seg = 7'h71;
      endcase
   endfunction

   assign boundary = (prev_sel == 2'd3) && (i_Sel == 2'd0);
   assign o_Ready  = !pending;

   // Swap and load are mutually exclusive: swap needs pending=1, load needs pending=0.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         active_data <= '0;
         active_dp   <= '0;
         shadow_data <= '0;
         shadow_dp   <= '0;
         pending     <= 1'b0;
         prev_sel    <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         prev_sel <= i_Sel;
         if (boundary && pending) begin
            active_data <= shadow_data;
            active_dp   <= shadow_dp;
            pending     <= 1'b0;
         end else if (i_Load && !pending) begin
            shadow_data <= i_Data;
            shadow_dp   <= i_Dp;
            pending     <= 1'b1;
         end
         if (boundary) begin
            if (blink_cnt == CNT_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= !blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      nib     = '0;
      lz_dark = 1'b0;
      case (i_Sel)
         2'd0: nib = active_data[3:0];
         2'd1: begin
            nib     = active_data[7:4];
            lz_dark = (active_data[15:4] == '0);
         end
         2'd2: begin
            nib     = active_data[11:8];
            lz_dark = (active_data[15:8] == '0);
         end
         default: begin
            nib     = active_data[15:12];
            lz_dark = (active_data[15:12] == '0);
         end
      endcase
      lz_dark    = lz_dark && i_Blank_Lz;
      blink_dark = i_Blink[i_Sel] && blink_phase;
      seg_raw    = (lz_dark || blink_dark) ? 7'h00 : hex_to_seg(nib);
      dp_raw     = blink_dark ? 1'b0 : active_dp[i_Sel];
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         o_Seg <= SEG_OFF;
         o_Dp  <= DP_OFF;
      end else begin
         o_Seg <= ACTIVE_LOW_SEG ? ~seg_raw : seg_raw;
         o_Dp  <= ACTIVE_LOW_SEG ? ~dp_raw : dp_raw;
      end
   end

endmodule
